// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request side: floor count, direction
// codes, per-request state encoding and position decode helpers.
package elevator_pkg;

  localparam int NUM_FLOORS = 4;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic {
    CALL_IDLE = 1'b0,
    CALL_HELD = 1'b1
  } call_state_e;

  // Car is stopped at a floor with the door open: even position, door open.
  function automatic logic at_floor(input logic [2:0] pos, input logic door_open);
    return !pos[0] && door_open;
  endfunction

  // Floor index (0 = floor1) of an even position; odd positions map to 0 and
  // must always be qualified by at_floor.
  function automatic logic [1:0] floor_idx(input logic [2:0] pos);
    return pos[0] ? 2'b00 : pos[2:1];
  endfunction

  // The illegal code 2'b11 behaves as stop, so it serves both directions.
  function automatic logic dir_serves_up(input logic [1:0] dir);
    return dir != DIR_DOWN;
  endfunction

  function automatic logic dir_serves_down(input logic [1:0] dir);
    return dir != DIR_UP;
  endfunction

endpackage

// File: rtl/elevator_call_panel_call_latch.sv
// One request bit: press edge detect, IDLE/HELD state and a saturating age.
// The cancel input only exists when CALL_CANCEL_EN is defined.
module call_latch
  import elevator_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int AGE_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic press,
  input  logic clr,
`ifdef CALL_CANCEL_EN
  input  logic cancel_en,
`endif
  output logic held,
  output logic starved_bit
);

  localparam logic [AGE_W-1:0] MAX_AGE = AGE_W'(MAX_WAIT);

  logic             press_q, press_d;
  call_state_e      state_q, state_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             starved_q, starved_d;
  logic             rise;

  always_comb begin
    press_d = press;
    rise    = press && !press_q;
    state_d = state_q;

    case (state_q)
      // A press arriving while the bit is being served is absorbed.
      CALL_IDLE: if (rise && !clr) state_d = CALL_HELD;
      CALL_HELD: begin
        if (clr) begin
          state_d = CALL_IDLE;
        end
`ifdef CALL_CANCEL_EN
        else if (cancel_en && rise) begin
          state_d = CALL_IDLE;
        end
`endif
      end
      default:   state_d = CALL_IDLE;
    endcase

    // Age counts only cycles spent in HELD; the set cycle starts it at 0.
    if (state_q == CALL_HELD && state_d == CALL_HELD) begin
      age_d = (age_q == MAX_AGE) ? age_q : age_q + 1'b1;
    end else begin
      age_d = '0;
    end

    starved_d = (age_d == MAX_AGE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      press_q   <= 1'b0;
      state_q   <= CALL_IDLE;
      age_q     <= '0;
      starved_q <= 1'b0;
    end else begin
      press_q   <= press_d;
      state_q   <= state_d;
      age_q     <= age_d;
      starved_q <= starved_d;
    end
  end

  assign held        = (state_q == CALL_HELD);
  assign starved_bit = starved_q;

endmodule

// File: rtl/elevator_call_panel.sv
// Hall/car call panel: latches button presses into held requests for the
// elevator controller and clears them when served. Optional CALL_CANCEL_EN
// lets a repeated car press cancel its request.
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int AGE_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] press_up,
  input  logic [2:0] press_down,
  input  logic [3:0] press_in,
  input  logic [2:0] position,
  input  logic       open,
  input  logic [1:0] direction,
  output logic [2:0] button_up,
  output logic [2:0] button_down,
  output logic [3:0] button_in,
  output logic       starved
);

  logic [2:0] clr_up;
  logic [2:0] clr_down;
  logic [3:0] clr_in;
  logic [2:0] starved_up;
  logic [2:0] starved_down;
  logic [3:0] starved_in;

  logic       stopped;
  logic [1:0] cur_floor;

  // Service decode: the hall-up bit for floor f is index f, the hall-down bit
  // for floor f is index f-1 (there is no down button on floor1).
  always_comb begin
    stopped   = at_floor(position, open);
    cur_floor = floor_idx(position);
    clr_up    = '0;
    clr_down  = '0;
    clr_in    = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      clr_in[i] = stopped && (cur_floor == 2'(i));
    end
    for (int i = 0; i < NUM_FLOORS - 1; i++) begin
      clr_up[i]   = stopped && dir_serves_up(direction)   && (cur_floor == 2'(i));
      clr_down[i] = stopped && dir_serves_down(direction) && (cur_floor == 2'(i + 1));
    end
  end

  genvar g;

  generate
    for (g = 0; g < NUM_FLOORS - 1; g++) begin : g_hall
      call_latch #(.MAX_WAIT(MAX_WAIT), .AGE_W(AGE_W)) u_up (
        .clk         (clk),
        .reset       (reset),
        .press       (press_up[g]),
        .clr         (clr_up[g]),
`ifdef CALL_CANCEL_EN
        .cancel_en   (1'b0),
`endif
        .held        (button_up[g]),
        .starved_bit (starved_up[g])
      );

      call_latch #(.MAX_WAIT(MAX_WAIT), .AGE_W(AGE_W)) u_down (
        .clk         (clk),
        .reset       (reset),
        .press       (press_down[g]),
        .clr         (clr_down[g]),
`ifdef CALL_CANCEL_EN
        .cancel_en   (1'b0),
`endif
        .held        (button_down[g]),
        .starved_bit (starved_down[g])
      );
    end

    for (g = 0; g < NUM_FLOORS; g++) begin : g_car
      call_latch #(.MAX_WAIT(MAX_WAIT), .AGE_W(AGE_W)) u_in (
        .clk         (clk),
        .reset       (reset),
        .press       (press_in[g]),
        .clr         (clr_in[g]),
`ifdef CALL_CANCEL_EN
        .cancel_en   (1'b1),
`endif
        .held        (button_in[g]),
        .starved_bit (starved_in[g])
      );
    end
  endgenerate

  // Each starved_bit is already a flop, so this OR is a registered view.
  assign starved = |{starved_up, starved_down, starved_in};

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel with MAX_WAIT=4.
module tb_elevator_call_panel;

  logic       clk;
  logic       reset;
  logic [2:0] press_up;
  logic [2:0] press_down;
  logic [3:0] press_in;
  logic [2:0] position;
  logic       open;
  logic [1:0] direction;
  logic [2:0] button_up;
  logic [2:0] button_down;
  logic [3:0] button_in;
  logic       starved;

  int n_cmp;
  int n_fail;

  elevator_call_panel #(.MAX_WAIT(4), .AGE_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .press_up    (press_up),
    .press_down  (press_down),
    .press_in    (press_in),
    .position    (position),
    .open        (open),
    .direction   (direction),
    .button_up   (button_up),
    .button_down (button_down),
    .button_in   (button_in),
    .starved     (starved)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    press_up   = '0;
    press_down = '0;
    press_in   = '0;
    position   = 3'b001;
    open       = 1'b0;
    direction  = 2'b00;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    n_cmp++;
    if (button_up !== 3'b000) begin
      n_fail++; $display("FAIL reset_up: got %b expected %b", button_up, 3'b000);
    end
    n_cmp++;
    if (button_down !== 3'b000) begin
      n_fail++; $display("FAIL reset_down: got %b expected %b", button_down, 3'b000);
    end
    n_cmp++;
    if (button_in !== 4'b0000) begin
      n_fail++; $display("FAIL reset_in: got %b expected %b", button_in, 4'b0000);
    end
    n_cmp++;
    if (starved !== 1'b0) begin
      n_fail++; $display("FAIL reset_starved: got %b expected %b", starved, 1'b0);
    end
    reset = 1'b0;
    step();
  endtask

  // Held press, door closed: one request, visible after the sampling edge,
  // starving after 4 cycles of age, then served at floor4.
  task automatic test_single_request();
    press_in = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (button_in !== 4'b1000) begin
        n_fail++; $display("FAIL hold_in[%0d]: got %b expected %b", i, button_in, 4'b1000);
      end
      n_cmp++;
      if (starved !== (i == 4)) begin
        n_fail++; $display("FAIL hold_starved[%0d]: got %b expected %b", i, starved, (i == 4));
      end
    end
    press_in = 4'b0000;
    step();
    n_cmp++;
    if (button_in !== 4'b1000) begin
      n_fail++; $display("FAIL release_in: got %b expected %b", button_in, 4'b1000);
    end
    n_cmp++;
    if ({button_up, button_down} !== 6'b0) begin
      n_fail++; $display("FAIL release_hall: got %b expected %b", {button_up, button_down}, 6'b0);
    end
    position = 3'b110;
    open     = 1'b1;
    step();
    n_cmp++;
    if (button_in !== 4'b0000) begin
      n_fail++; $display("FAIL serve_in4: got %b expected %b", button_in, 4'b0000);
    end
    n_cmp++;
    if (starved !== 1'b0) begin
      n_fail++; $display("FAIL serve_in4_starved: got %b expected %b", starved, 1'b0);
    end
    idle_inputs();
    step();
  endtask

  // Hall-up at floor2: kept while moving down, cleared when moving up.
  // Hall-down at floor2 is cleared when direction is the illegal code.
  task automatic test_direction_clear();
    press_up   = 3'b010;
    press_down = 3'b001;
    step();
    press_up   = 3'b000;
    press_down = 3'b000;
    n_cmp++;
    if (button_up !== 3'b010) begin
      n_fail++; $display("FAIL up_set: got %b expected %b", button_up, 3'b010);
    end
    position  = 3'b010;
    open      = 1'b1;
    direction = 2'b10;
    step();
    n_cmp++;
    if (button_up !== 3'b010) begin
      n_fail++; $display("FAIL up_kept_dir_down: got %b expected %b", button_up, 3'b010);
    end
    n_cmp++;
    if (button_down !== 3'b000) begin
      n_fail++; $display("FAIL down_cleared_dir_down: got %b expected %b", button_down, 3'b000);
    end
    direction = 2'b01;
    step();
    n_cmp++;
    if (button_up !== 3'b000) begin
      n_fail++; $display("FAIL up_cleared_dir_up: got %b expected %b", button_up, 3'b000);
    end
    open       = 1'b0;
    press_down = 3'b001;
    step();
    press_down = 3'b000;
    open       = 1'b1;
    direction  = 2'b01;
    step();
    n_cmp++;
    if (button_down !== 3'b001) begin
      n_fail++; $display("FAIL down_kept_dir_up: got %b expected %b", button_down, 3'b001);
    end
    direction = 2'b11;
    step();
    n_cmp++;
    if (button_down !== 3'b000) begin
      n_fail++; $display("FAIL down_cleared_dir_illegal: got %b expected %b", button_down, 3'b000);
    end
    idle_inputs();
    step();
  endtask

  // Press edges on bits being served in the same cycle are absorbed.
  task automatic test_collision();
    position   = 3'b100;
    open       = 1'b1;
    direction  = 2'b00;
    press_down = 3'b010;
    press_in   = 4'b0100;
    step();
    n_cmp++;
    if (button_down !== 3'b000) begin
      n_fail++; $display("FAIL collide_down: got %b expected %b", button_down, 3'b000);
    end
    n_cmp++;
    if (button_in !== 4'b0000) begin
      n_fail++; $display("FAIL collide_in: got %b expected %b", button_in, 4'b0000);
    end
    open = 1'b0;
    step();
    n_cmp++;
    if (button_down !== 3'b000) begin
      n_fail++; $display("FAIL collide_no_late_set: got %b expected %b", button_down, 3'b000);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_starvation();
    press_in = 4'b0001;
    step();
    press_in = 4'b0000;
    n_cmp++;
    if (button_in !== 4'b0001) begin
      n_fail++; $display("FAIL starve_set: got %b expected %b", button_in, 4'b0001);
    end
    step();
    step();
    step();
    n_cmp++;
    if (starved !== 1'b0) begin
      n_fail++; $display("FAIL starve_age3: got %b expected %b", starved, 1'b0);
    end
    step();
    n_cmp++;
    if (starved !== 1'b1) begin
      n_fail++; $display("FAIL starve_age4: got %b expected %b", starved, 1'b1);
    end
    step();
    n_cmp++;
    if (starved !== 1'b1) begin
      n_fail++; $display("FAIL starve_saturate: got %b expected %b", starved, 1'b1);
    end
    position = 3'b000;
    open     = 1'b1;
    step();
    n_cmp++;
    if (button_in !== 4'b0000) begin
      n_fail++; $display("FAIL starve_serve_in: got %b expected %b", button_in, 4'b0000);
    end
    n_cmp++;
    if (starved !== 1'b0) begin
      n_fail++; $display("FAIL starve_drop: got %b expected %b", starved, 1'b0);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    press_up   = 3'b111;
    press_down = 3'b111;
    press_in   = 4'b1111;
    step();
    idle_inputs();
    n_cmp++;
    if ({button_up, button_down, button_in} !== 10'h3ff) begin
      n_fail++; $display("FAIL midreset_pre: got %b expected %b", {button_up, button_down, button_in}, 10'h3ff);
    end
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if ({button_up, button_down, button_in} !== 10'h000) begin
      n_fail++; $display("FAIL midreset_buttons: got %b expected %b", {button_up, button_down, button_in}, 10'h000);
    end
    n_cmp++;
    if (starved !== 1'b0) begin
      n_fail++; $display("FAIL midreset_starved: got %b expected %b", starved, 1'b0);
    end
    step();
  endtask

  task automatic test_back_to_back_press();
    logic [3:0] exp_in;
`ifdef CALL_CANCEL_EN
    exp_in = 4'b0000;
`else
    exp_in = 4'b0100;
`endif
    press_in = 4'b0100;
    step();
    n_cmp++;
    if (button_in !== 4'b0100) begin
      n_fail++; $display("FAIL repress_first: got %b expected %b", button_in, 4'b0100);
    end
    press_in = 4'b0000;
    step();
    press_in = 4'b0100;
    step();
    press_in = 4'b0000;
    n_cmp++;
    if (button_in !== exp_in) begin
      n_fail++; $display("FAIL repress_second: got %b expected %b", button_in, exp_in);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_single_request();
    test_direction_clear();
    test_collision();
    test_starvation();
    test_reset_mid();
    test_back_to_back_press();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
